tape_filter: RTL and testbench

Tape input conditioner between the raw `tape_in` pin and its consumers: the ports block (bit 6 of port FE), the mixer tape echo, and the turbo/magic logic. It synchronises and debounces the comparator output, measures half-periods in 3.5 MHz ticks, and flags loader pilot tone and tape activity. The CPU controller uses these flags to drop turbo automatically while a tape is loading.

---
 rtl/tape_filter.sv | 174 +++++++++++++++++
 tb/tb_tape_filter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tape_filter.sv
// tape_filter: conditions the raw tape comparator input for the ports block,
// the mixer echo and the turbo logic.
//   clk28        in   28 MHz system clock
//   rst_n        in   synchronous active-low reset
//   ck35         in   one-cycle 3.5 MHz strobe qualifying all state updates
//   tape_in      in   raw asynchronous comparator input
//   tape_clean   out  debounced tape level
//   tape_edge    out  one-cycle pulse on every tape_clean transition
//   half_period  out  last measured half-period in ck35 ticks (saturates at 4095)
//   period_valid out  one-cycle pulse when half_period is updated
//   pilot        out  loader pilot tone locked
//   active       out  tape signal present
module tape_filter #(
   parameter int FILT_MAX       = 7,
   parameter int PILOT_MIN      = 1850,
   parameter int PILOT_MAX      = 2500,
   parameter int PILOT_COUNT    = 256,
   parameter int ACTIVE_TIMEOUT = 1_750_000
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        ck35,
   input  logic        tape_in,
   output logic        tape_clean,
   output logic        tape_edge,
   output logic [11:0] half_period,
   output logic        period_valid,
   output logic        pilot,
   output logic        active
);

   localparam logic [3:0]  FMAX = 4'(FILT_MAX);
   localparam logic [11:0] PMIN = 12'(PILOT_MIN);
   localparam logic [11:0] PMAX = 12'(PILOT_MAX);
   localparam logic [9:0]  PCNT = 10'(PILOT_COUNT);
   localparam logic [20:0] TMO  = 21'(ACTIVE_TIMEOUT);

   typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

   logic        tin_m, tin_s;
   logic [3:0]  fcnt, fcnt_n;
   logic        clean_n, edge_c, timeout_c;
   logic [11:0] pcnt;
   logic [20:0] icnt;
   logic        armed;
   logic        in_range;
   logic [9:0]  run, run_n;
   state_t      state, state_n;

   function automatic logic [11:0] sat_inc12(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   // Synchroniser: free-running on clk28, no reset needed on a pure delay line.
   always_ff @(posedge clk28) begin
      tin_m <= tape_in;
      tin_s <= tin_m;
   end

   // Integrator, hysteresis and edge/timeout detection for the current tick.
   always_comb begin
      fcnt_n = fcnt;
      if (tin_s && (fcnt < FMAX))
         fcnt_n = fcnt + 4'd1;
      else if (!tin_s && (fcnt != 4'd0))
         fcnt_n = fcnt - 4'd1;

      clean_n = tape_clean;
      if (fcnt_n == FMAX)
         clean_n = 1'b1;
      else if (fcnt_n == 4'd0)
         clean_n = 1'b0;

      edge_c = ck35 && (clean_n != tape_clean);
      // An edge on the timeout tick clears icnt instead of timing out.
      timeout_c = ck35 && !edge_c && (icnt == TMO - 21'd1);
   end

   // Measurement stage: period/idle counters and the armed flag.
   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         fcnt         <= 4'd0;
         tape_clean   <= 1'b0;
         tape_edge    <= 1'b0;
         pcnt         <= 12'd0;
         icnt         <= 21'd0;
         armed        <= 1'b1;
         half_period  <= 12'd0;
         period_valid <= 1'b0;
      end else begin
         tape_edge    <= edge_c;
         period_valid <= 1'b0;
         if (ck35) begin
            fcnt       <= fcnt_n;
            tape_clean <= clean_n;
            if (edge_c) begin
               pcnt <= 12'd0;
               icnt <= 21'd0;
               // The first edge after arming only starts the measurement.
               if (armed) begin
                  armed <= 1'b0;
               end else begin
                  half_period  <= sat_inc12(pcnt);
                  period_valid <= 1'b1;
               end
            end else begin
               pcnt <= sat_inc12(pcnt);
               if (icnt != TMO)
                  icnt <= icnt + 21'd1;
               if (timeout_c)
                  armed <= 1'b1;
            end
         end
      end
   end

   // Pilot FSM: advances on each period_valid using the freshly stored period.
   always_comb begin
      state_n  = state;
      run_n    = run;
      in_range = (half_period >= PMIN) && (half_period <= PMAX);
      if (timeout_c) begin
         state_n = IDLE;
         run_n   = 10'd0;
      end else if (period_valid) begin
         case (state)
            IDLE: begin
               if (in_range) begin
                  state_n = COUNT;
                  run_n   = 10'd1;
               end
            end
            COUNT: begin
               if (in_range) begin
                  run_n = run + 10'd1;
                  if (run + 10'd1 == PCNT)
                     state_n = LOCKED;
               end else begin
                  state_n = IDLE;
                  run_n   = 10'd0;
               end
            end
            LOCKED: begin
               if (!in_range) begin
                  state_n = IDLE;
                  run_n   = 10'd0;
               end
            end
            default: begin
               state_n = IDLE;
               run_n   = 10'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state  <= IDLE;
         run    <= 10'd0;
         pilot  <= 1'b0;
         active <= 1'b0;
      end else begin
         state <= state_n;
         run   <= run_n;
         pilot <= (state_n == LOCKED);
         if (timeout_c)
            active <= 1'b0;
         else if (period_valid)
            active <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tape_filter.sv
// Scoreboard bench for tape_filter: stimulus pushes expected period reports,
// a monitor pops them on every period_valid. Scaled pilot/timeout parameters.
module tb_tape_filter;

   logic        clk28, rst_n, ck35, tape_in;
   logic        tape_clean, tape_edge, period_valid, pilot, active;
   logic [11:0] half_period;

   tape_filter #(
      .FILT_MAX(7), .PILOT_MIN(18), .PILOT_MAX(25),
      .PILOT_COUNT(8), .ACTIVE_TIMEOUT(4500)
   ) dut (
      .clk28(clk28), .rst_n(rst_n), .ck35(ck35), .tape_in(tape_in),
      .tape_clean(tape_clean), .tape_edge(tape_edge),
      .half_period(half_period), .period_valid(period_valid),
      .pilot(pilot), .active(active)
   );

   typedef struct { int hp; bit pil; bit act; } exp_t;
   exp_t sbq[$];
   exp_t cur;
   bit   pend;
   int   n_vec, n_bad, n_edges;
   int   div, phase;

   int hd[20] = '{20,18,25,20,20,20,20,20,20,20,20,17,20,20,20,20,20,20,26,20};
   bit pd[19] = '{0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,0,0,0,0};

   initial begin
      clk28 = 1'b0;
      forever #5 clk28 = ~clk28;
   end

   initial begin
      ck35  = 1'b0;
      phase = 0;
      forever begin
         @(negedge clk28);
         phase = (phase + 1 >= div) ? 0 : phase + 1;
         ck35  = (phase == 0);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, finished 0 expected 1");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int hp, input bit pil);
      sbq.push_back('{hp, pil, 1'b1});
   endtask

   // Wait for n ck35 ticks, return just after the last sampling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk28); while (ck35 !== 1'b1);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk28);
      #1;
      check("rst_tape_clean", tape_clean, 0);
      check("rst_tape_edge", tape_edge, 0);
      check("rst_half_period", half_period, 0);
      check("rst_period_valid", period_valid, 0);
      check("rst_pilot", pilot, 0);
      check("rst_active", active, 0);
      tape_in = 1'b0;
      repeat (3) @(posedge clk28);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: counts edges, pops expectations on each period_valid and
   // checks pilot/active one cycle later.
   initial begin
      pend    = 1'b0;
      n_edges = 0;
      forever begin
         @(negedge clk28);
         if (pend) begin
            check("pilot_after_pv", pilot, cur.pil);
            check("active_after_pv", active, cur.act);
            pend = 1'b0;
         end
         if (tape_edge) n_edges++;
         if (period_valid) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_pv: half_period %0d, expected no period_valid", half_period);
            end else begin
               cur = sbq.pop_front();
               check("half_period", half_period, cur.hp);
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      int e0;
      n_vec   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      tape_in = 1'b1;
      div     = 8;

      // Reset with tape_in high, then glitch rejection at ck35 = clk28/8.
      do_reset();
      tick(2);
      e0 = n_edges;
      tape_in = 1'b1; tick(3);
      tape_in = 1'b0; tick(10);
      check("glitch_edges", n_edges - e0, 0);
      check("glitch_clean", tape_clean, 0);
      tape_in = 1'b1; tick(6);
      check("rise_clean_early", tape_clean, 0);
      tick(1);
      check("rise_clean", tape_clean, 1);
      check("rise_edge", tape_edge, 1);
      tick(13);
      push(20, 1'b0);
      tape_in = 1'b0; tick(6);
      check("fall_clean_early", tape_clean, 1);
      tick(1);
      check("fall_clean", tape_clean, 0);
      check("fall_edge", tape_edge, 1);
      tick(5);
      check("pulse_edges", n_edges - e0, 2);

      // Period measurement and 4095 saturation.
      div = 3;
      do_reset();
      tape_in = 1'b1; tick(855);
      push(855, 1'b0);
      tape_in = 1'b0; tick(855);
      push(855, 1'b0);
      tape_in = 1'b1; tick(855); tick(3300);
      push(4095, 1'b0);
      tape_in = 1'b0; tick(20);

      // Pilot lock, loss on a short half, and a run that never locks.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i > 0) push(hd[i-1], pd[i-1]);
         tape_in = ~tape_in;
         tick(hd[i]);
      end

      // Timeout, re-arm, and an edge landing on the timeout tick.
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) push(20, (i - 1) >= 8);
         tape_in = ~tape_in;
         tick(20);
      end
      tick(4486);
      check("active_pre_timeout", active, 1);
      check("pilot_pre_timeout", pilot, 1);
      tick(1);
      check("active_timeout", active, 0);
      check("pilot_timeout", pilot, 0);
      tape_in = ~tape_in; tick(20);
      check("rearm_active", active, 0);
      push(20, 1'b0);
      tape_in = ~tape_in; tick(20);
      tick(4479);
      check("active_pre_race", active, 1);
      tick(1);
      push(4095, 1'b0);
      tape_in = ~tape_in; tick(6);
      check("active_race_minus1", active, 1);
      tick(1);
      check("race_edge", tape_edge, 1);
      check("active_race", active, 1);
      tick(20);
      push(27, 1'b0);
      tape_in = ~tape_in; tick(20);

      tick(10);
      check("queue_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
